// File: rtl/timer555_pkg.sv
// Shared types for the 555-style multimode timer: FSM states and mode encodings.
package timer555_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ASTABLE = 2'd1;
  localparam logic [1:0] MODE_MONO    = 2'd2;

endpackage

// File: rtl/timer555_prescaler.sv
// Free-running divide-by-PRESCALE tick generator; tick is high one cycle in PRESCALE.
module timer555_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DIV_W = $clog2(PRESCALE) + 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(PRESCALE - 1);

  logic [DIV_W-1:0] r_div;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (r_div == LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign tick = (r_div == LAST);

endmodule

// File: rtl/timer555_multimode.sv
// Clocked 555 timer: astable / monostable pulse generator on one loadable down-counter.
// Optional tick prescaler is enabled by defining TIMER555_PRESCALER_EN.
module timer555_multimode
  import timer555_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             trigger,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] low_cycles,
  output logic             pulse,
  output logic             busy,
  output logic             period_done,
  output logic [CNT_W-1:0] cycles
);

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [CNT_W-1:0] r_cycles, w_cycles;
  logic             r_pulse, w_pulse;
  logic             r_pd, w_pd;
  logic             r_trig_q;
  logic             w_tick;
  logic             w_trig_edge;
  logic             w_phase_end;
  logic [CNT_W-1:0] w_high_load;
  logic [CNT_W-1:0] w_low_load;

`ifdef TIMER555_PRESCALER_EN
  timer555_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  // Zero durations load as one tick so every phase lasts at least one tick.
  assign w_high_load = (high_cycles == '0) ? '0 : high_cycles - CNT_W'(1);
  assign w_low_load  = (low_cycles  == '0) ? '0 : low_cycles  - CNT_W'(1);
  assign w_trig_edge = trigger & ~r_trig_q;
  assign w_phase_end = w_tick && (r_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_cycles <= '0;
      r_pulse  <= 1'b0;
      r_pd     <= 1'b0;
      r_trig_q <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_cycles <= w_cycles;
      r_pulse  <= w_pulse;
      r_pd     <= w_pd;
      r_trig_q <= trigger;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_cycles = r_cycles;
    w_pulse  = r_pulse;
    w_pd     = 1'b0;
    if (!en) begin
      w_state = IDLE;
      w_pulse = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if ((mode == MODE_ASTABLE) || ((mode == MODE_MONO) && w_trig_edge)) begin
            w_state = HIGH;
            w_cnt   = w_high_load;
            w_pulse = 1'b1;
          end
        end
        HIGH: begin
          if (w_phase_end) begin
            w_pulse = 1'b0;
            if (mode == MODE_MONO) begin
              w_state  = IDLE;
              w_pd     = 1'b1;
              w_cycles = r_cycles + CNT_W'(1);
            end else begin
              w_state = LOW;
              w_cnt   = w_low_load;
            end
          end else if (w_tick) begin
            w_cnt = r_cnt - CNT_W'(1);
          end
        end
        LOW: begin
          if (w_phase_end) begin
            w_pd     = 1'b1;
            w_cycles = r_cycles + CNT_W'(1);
            if (mode == MODE_ASTABLE) begin
              w_state = HIGH;
              w_cnt   = w_high_load;
              w_pulse = 1'b1;
            end else begin
              w_state = IDLE;
              w_pulse = 1'b0;
            end
          end else if (w_tick) begin
            w_cnt = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_state = IDLE;
          w_pulse = 1'b0;
        end
      endcase
    end
  end

  assign pulse       = r_pulse;
  assign busy        = (r_state != IDLE);
  assign period_done = r_pd;
  assign cycles      = r_cycles;

endmodule

// File: tb/tb_timer555_multimode.sv
// Self-checking bench for timer555_multimode using a per-cycle expected-value scoreboard.
module tb_timer555_multimode;

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned PRESCALE = 4;

  typedef struct packed {
    logic             pulse;
    logic             busy;
    logic             pd;
    logic [CNT_W-1:0] cycles;
  } obs_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [1:0]       mode;
  logic             trigger;
  logic [CNT_W-1:0] high_cycles;
  logic [CNT_W-1:0] low_cycles;
  logic             pulse;
  logic             busy;
  logic             period_done;
  logic [CNT_W-1:0] cycles;

  int unsigned checks = 0;
  int unsigned errors = 0;
  obs_t        sb[$];

  timer555_multimode #(
    .CNT_W   (CNT_W),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .mode       (mode),
    .trigger    (trigger),
    .high_cycles(high_cycles),
    .low_cycles (low_cycles),
    .pulse      (pulse),
    .busy       (busy),
    .period_done(period_done),
    .cycles     (cycles)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic p, input logic b, input logic d, input int unsigned c);
    obs_t o;
    o.pulse  = p;
    o.busy   = b;
    o.pd     = d;
    o.cycles = CNT_W'(c);
    return o;
  endfunction

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; mode = 2'd0; trigger = 1'b0;
    high_cycles = '0; low_cycles = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o, e;
    reset = 1'b1; en = 1'b0; mode = 2'd0; trigger = 1'b0;
    high_cycles = '0; low_cycles = '0;
    #2;
    sb.push_back(mk(1'b0, 1'b0, 1'b0, 0));
    o = {pulse, busy, period_done, cycles};
    e = sb.pop_front();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset: got p=%b b=%b d=%b c=%0d want p=%b b=%b d=%b c=%0d",
               o.pulse, o.busy, o.pd, o.cycles, e.pulse, e.busy, e.pd, e.cycles);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_astable();
    obs_t o, e;
    do_reset();
    high_cycles = 16'd3; low_cycles = 16'd2; mode = 2'd1; en = 1'b1;
    for (int j = 0; j <= 20; j++) begin
      sb.push_back(mk((j % 5) < 3, 1'b1, (j > 0) && (j % 5 == 0), j / 5));
      @(posedge clk); #1;
      o = {pulse, busy, period_done, cycles};
      e = sb.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL astable[%0d]: got p=%b b=%b d=%b c=%0d want p=%b b=%b d=%b c=%0d", j,
                 o.pulse, o.busy, o.pd, o.cycles, e.pulse, e.busy, e.pd, e.cycles);
      end
    end
  endtask

  task automatic test_monostable();
    obs_t o, e;
    do_reset();
    high_cycles = 16'd4; low_cycles = 16'd7; mode = 2'd2; en = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b1;
    for (int j = 0; j < 8; j++) begin
      // second rising edge lands while HIGH and must be ignored
      if (j == 1) trigger = 1'b0;
      if (j == 2) trigger = 1'b1;
      sb.push_back(mk(j < 4, j < 4, j == 4, (j >= 4) ? 1 : 0));
      @(posedge clk); #1;
      o = {pulse, busy, period_done, cycles};
      e = sb.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL mono[%0d]: got p=%b b=%b d=%b c=%0d want p=%b b=%b d=%b c=%0d", j,
                 o.pulse, o.busy, o.pd, o.cycles, e.pulse, e.busy, e.pd, e.cycles);
      end
    end
  endtask

  task automatic test_zero_duration();
    obs_t o, e;
    do_reset();
    high_cycles = '0; low_cycles = '0; mode = 2'd1; en = 1'b1;
    for (int j = 0; j < 10; j++) begin
      sb.push_back(mk(j % 2 == 0, 1'b1, (j > 0) && (j % 2 == 0), j / 2));
      @(posedge clk); #1;
      o = {pulse, busy, period_done, cycles};
      e = sb.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL zero[%0d]: got p=%b b=%b d=%b c=%0d want p=%b b=%b d=%b c=%0d", j,
                 o.pulse, o.busy, o.pd, o.cycles, e.pulse, e.busy, e.pd, e.cycles);
      end
    end
  endtask

  task automatic test_reset_mid_high();
    obs_t o, e;
    do_reset();
    high_cycles = 16'd5; low_cycles = 16'd5; mode = 2'd1; en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    sb.push_back(mk(1'b0, 1'b0, 1'b0, 0));
    o = {pulse, busy, period_done, cycles};
    e = sb.pop_front();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL async_reset: got p=%b b=%b d=%b c=%0d want p=%b b=%b d=%b c=%0d",
               o.pulse, o.busy, o.pd, o.cycles, e.pulse, e.busy, e.pd, e.cycles);
    end
    @(posedge clk); #1;
    mode = 2'd2; trigger = 1'b0;
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      sb.push_back(mk(1'b0, 1'b0, 1'b0, 0));
      @(posedge clk); #1;
      o = {pulse, busy, period_done, cycles};
      e = sb.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL post_reset_idle[%0d]: got p=%b b=%b d=%b c=%0d want p=%b b=%b d=%b c=%0d", j,
                 o.pulse, o.busy, o.pd, o.cycles, e.pulse, e.busy, e.pd, e.cycles);
      end
    end
  endtask

  task automatic test_en_drop();
    obs_t o, e;
    do_reset();
    high_cycles = 16'd2; low_cycles = 16'd3; mode = 2'd1; en = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j == 5) en = 1'b0;
      sb.push_back(mk((j < 2) ? 1'b1 : 1'b0, j < 5, 1'b0, 0));
      @(posedge clk); #1;
      o = {pulse, busy, period_done, cycles};
      e = sb.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL en_drop[%0d]: got p=%b b=%b d=%b c=%0d want p=%b b=%b d=%b c=%0d", j,
                 o.pulse, o.busy, o.pd, o.cycles, e.pulse, e.busy, e.pd, e.cycles);
      end
    end
  endtask

  task automatic test_prescaler();
    int unsigned width;
    int unsigned wait_cyc;
    do_reset();
    high_cycles = 16'd2; low_cycles = '0; mode = 2'd2; en = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    width = 0;
    wait_cyc = 0;
    while (pulse === 1'b1 && wait_cyc < 64) begin
      width++;
      wait_cyc++;
      @(posedge clk); #1;
    end
    checks++;
    if (width < 5 || width > 8) begin
      errors++;
      $display("FAIL presc_first: got width=%0d want 5..8", width);
    end
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
    end
    trigger = 1'b1;
    @(posedge clk); #1;
    width = 0;
    wait_cyc = 0;
    while (pulse === 1'b1 && wait_cyc < 64) begin
      width++;
      wait_cyc++;
      @(posedge clk); #1;
    end
    checks++;
    if (width != 8) begin
      errors++;
      $display("FAIL presc_aligned: got width=%0d want 8", width);
    end
    trigger = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = 2'd0; trigger = 1'b0;
    high_cycles = '0; low_cycles = '0;
    test_reset();
`ifdef TIMER555_PRESCALER_EN
    test_prescaler();
`else
    test_astable();
    test_monostable();
    test_zero_duration();
    test_reset_mid_high();
    test_en_drop();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

`ifndef TIMER555_PRESCALER_EN
  initial begin
    if (0) test_prescaler();
  end
`endif

endmodule

// File: doc/timer555_multimode.md
# timer555_multimode

Clocked, synthesizable successor to the delay-based 555 timer model. A single loadable down-counter produces a pulse in astable (free-running, programmable high/low) or monostable (one-shot on trigger edge) mode. Durations are run-time inputs, not elaboration constants. The block sits between a control register file and any logic that needs a periodic or one-shot enable pulse.

## Interface
- CNT_W, 16, width of duration inputs, internal counter and `cycles`
- PRESCALE, 1, clock divider ratio; used only when `TIMER555_PRESCALER_EN` is defined, must be ≥1
- clk  in  1  single clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- en  in  1  timer enable; low forces IDLE
- mode  in  2  0=OFF, 1=ASTABLE, 2=MONOSTABLE, 3=reserved (treated as OFF)
- trigger  in  1  monostable start, rising-edge detected
- high_cycles  in  CNT_W  pulse-high duration in ticks
- low_cycles  in  CNT_W  pulse-low duration in ticks (astable only)
- pulse  out  1  registered timer output
- busy  out  1  state ≠ IDLE
- period_done  out  1  one-cycle strobe at the end of each astable LOW phase or monostable HIGH phase
- cycles  out  CNT_W  completed periods/shots since reset, wraps modulo 2^CNT_W

## Operation
- States: IDLE, HIGH, LOW. Reset: state=IDLE, pulse=0, busy=0, period_done=0, cycles=0, counter=0, trigger history=0.
- Tick: every cycle without prescaler; otherwise one cycle in PRESCALE. The counter decrements only on ticks.
- Duration load: counter ← max(N,1)−1 on phase entry; N is sampled in that cycle. A zero duration is treated as 1. Input changes mid-phase have no effect until the next phase entry.
- IDLE→HIGH (astable): en=1 and mode=1. Pulse goes high.
- IDLE→HIGH (monostable): en=1, mode=2, and trig_edge = trigger & ~trigger_q.
- HIGH, counter=0 on tick:
  - astable → LOW, pulse=0.
  - monostable → IDLE, pulse=0, period_done=1, cycles+1.
- LOW, counter=0 on tick: if mode is still 1, go to HIGH and assert period_done and cycles+1. Otherwise go to IDLE and still assert period_done and cycles+1.
- Trigger edges in HIGH or LOW are ignored (no retrigger).
- en=0 in any state: IDLE on the next edge, pulse=0, no period_done, and the count is not incremented. en low takes priority over a coincident phase end.
- Mode changes take effect only at phase boundaries, except that en=0 aborts immediately.

## Timing
- Latency is 1 cycle from the qualifying edge to pulse=1. en/mode/trigger are sampled at edge k, and pulse is high after edge k.
- Without prescaler: pulse is high for exactly max(H,1) cycles and low for max(L,1) cycles. The astable period is max(H,1)+max(L,1).
- With prescaler: phase lengths are multiplied by PRESCALE. The first phase may be up to PRESCALE−1 cycles short, because the prescaler free-runs.
- period_done is high in the same cycle as the transition out of the final phase, for one cycle. cycles updates on that same edge.
- Asynchronous reset mid-phase clears pulse immediately, without waiting for a clock.

## Configuration
- `TIMER555_PRESCALER_EN` defined: a free-running divide-by-PRESCALE counter (width $clog2(PRESCALE)+1) generates the tick. The divider is cleared by reset.
- Not defined: tick tied to 1, PRESCALE ignored, no divider logic synthesized.

## Structure
- Package `timer555_pkg`: state enum (IDLE/HIGH/LOW) and mode constants (MODE_OFF, MODE_ASTABLE, MODE_MONO).
- Sub-module `timer555_prescaler` (PRESCALE parameter; clk, reset, tick out), instantiated only under the macro.

## Test plan
- Astable, H=3, L=2, en=1: pulse shows the repeating pattern 1,1,1,0,0. period_done fires every 5 cycles. cycles=4 after 20 cycles.
- Monostable, H=4, one trigger edge: pulse high for 4 cycles, then IDLE. A second edge during HIGH is ignored; cycles=1.
- H=0, L=0, astable: pulse alternates 1,0 every cycle, with period 2.
- Reset asserted mid-HIGH: pulse=0 and busy=0 asynchronously. After release, the block stays IDLE until its start condition is met again.
- en dropped in the last LOW cycle: IDLE next edge, no period_done, cycles unchanged.
- With `TIMER555_PRESCALER_EN`, PRESCALE=4, monostable H=2: pulse width is 5–8 cycles for the first shot and 8 cycles when the trigger is aligned to a tick.
